mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Memory stage of the pipelined CPU, directly downstream of the execution stage.
- Consumes the EX/MEM pipeline register outputs: ALU result, store data, register-write controls and destination register.
- Runs load/store transactions on a req/ack data-memory port and stalls the upstream pipeline while a transaction is in flight.
- Drives the MEM/WB pipeline register, whose write-back data also forms the MEM-side forwarding source for the execution stage.

Parameters:
- TIMEOUT, 16: maximum number of BUSY cycles to wait for mem_ack before the access is aborted.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- RegWrite_MEM_in  input  1  instruction writes the register file.
- write_enable_MEM_in  input  1  instruction is a store.
- memtoreg_sel_MEM_in  input  1  instruction is a load; write-back data comes from memory.
- WriteRegister_MEM_in  input  5  destination register.
- alu_result_MEM_in  input  64  effective address, or ALU result for non-memory instructions.
- ReadData2_MEM_in  input  64  store data.
- mem_ack  input  1  memory completes the current request.
- mem_rdata  input  64  load data; valid only when mem_ack=1.
- mem_req  output  1  memory request (registered).
- mem_we  output  1  1 = write, 0 = read (registered).
- mem_addr  output  64  access address (registered).
- mem_wdata  output  64  store data (registered).
- stall_MEM  output  1  freezes all upstream stages (combinational).
- RegWrite_MEM_out  output  1  MEM/WB register-write enable.
- WriteRegister_MEM_out  output  5  MEM/WB destination register.
- WriteData_MEM_out  output  64  MEM/WB write-back data; also the forwarding source to EX.
- misaligned_err  output  1  sticky misaligned-access flag.
- timeout_err  output  1  sticky memory-timeout flag.

Behaviour:
- Access is defined as acc = write_enable_MEM_in | memtoreg_sel_MEM_in.
- An access is aligned when alu_result_MEM_in[2:0] == 0.
- Reset (synchronous): state=IDLE, timeout counter=0, and every output listed below is 0:
  - mem_req, mem_we, mem_addr, mem_wdata;
  - RegWrite_MEM_out, WriteRegister_MEM_out, WriteData_MEM_out;
  - misaligned_err, timeout_err.
- Reset asserted mid-transaction aborts it. mem_req is 0 in the following cycle, and no write-back occurs.
- The FSM has three states: IDLE, BUSY and DONE.
- IDLE, no access: stall_MEM=0. The MEM/WB register loads the inputs at the edge, with WriteData = alu_result. Latency is one cycle.
- IDLE, acc and aligned: stall_MEM=1.
  - At the edge, latch mem_addr=alu_result, mem_wdata=ReadData2, mem_we=write_enable, and set mem_req=1.
  - Clear the counter and go to BUSY.
  - MEM/WB loads a bubble (RegWrite_MEM_out=0, other MEM/WB fields hold).
- IDLE, acc and misaligned: stall_MEM=0.
  - Set misaligned_err.
  - Issue no request.
  - MEM/WB loads WriteRegister and WriteData=alu_result, but RegWrite_MEM_out=0.
- BUSY: stall_MEM=1, mem_req held at 1, and the counter increments each cycle. MEM/WB loads a bubble.
  - On mem_ack: capture mem_rdata into the internal load buffer, drop mem_req, go to DONE.
  - Counter reaches TIMEOUT-1 without ack: set timeout_err, load buffer=0, drop mem_req, go to DONE.
  - mem_ack in the same cycle as the timeout: the ack wins and timeout_err is not set.
- DONE: stall_MEM=0 and the upstream inputs are still those of the held instruction. At the edge:
  - MEM/WB loads RegWrite_MEM_in and WriteRegister_MEM_in.
  - WriteData = load buffer if memtoreg_sel, else alu_result.
  - Go to IDLE.
  - A store passes through RegWrite as presented; the decoder drives it to 0 for stores.
- A zero-wait memory (ack in the first BUSY cycle) costs 2 stall cycles per access.
- mem_ack outside BUSY is ignored.
- mem_we, mem_addr and mem_wdata hold their values until the next request is latched.
- The sticky flags are cleared only by reset.

Test Plan:
1. Reset, then an ALU op with RegWrite=1, Wreg=5, alu_result=0x2A and acc=0 → after one edge: RegWrite_MEM_out=1, WriteRegister_MEM_out=5, WriteData_MEM_out=0x2A; stall_MEM never asserted.
2. Load at addr 0x100, Wreg=3, mem_ack in the first BUSY cycle with rdata=0xDEADBEEF → stall_MEM=1 for exactly 2 cycles and mem_req=1 for exactly 1 cycle with mem_we=0 and mem_addr=0x100; after DONE, WriteData_MEM_out=0xDEADBEEF and RegWrite_MEM_out=1.
3. Store at addr 0x18 with data 0x55 and ack after 4 cycles → mem_we=1, mem_wdata=0x55, mem_req=1 for 4 cycles; a bubble (RegWrite_MEM_out=0) throughout the stall.
4. Load at addr 0x103 → misaligned_err=1, mem_req stays 0, no stall, RegWrite_MEM_out=0; the flag remains set after subsequent instructions until reset.
5. Load with ack never asserted → mem_req drops after TIMEOUT=16 cycles, timeout_err=1, WriteData_MEM_out=0, pipeline resumes. Repeat with the ack arriving in the final cycle → data captured and timeout_err=0.
6. Assert reset during BUSY → mem_req=0 and state=IDLE next cycle, all outputs 0; a later mem_ack is ignored.

Source files
------------

// File: rtl/mem_access.sv
// Memory stage: runs load/store transactions on a req/ack port, stalls upstream
// while a transaction is in flight, and drives the MEM/WB pipeline register.
module mem_access #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_MEM_in,
    input  logic        write_enable_MEM_in,
    input  logic        memtoreg_sel_MEM_in,
    input  logic [4:0]  WriteRegister_MEM_in,
    input  logic [63:0] alu_result_MEM_in,
    input  logic [63:0] ReadData2_MEM_in,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic        stall_MEM,
    output logic        RegWrite_MEM_out,
    output logic [4:0]  WriteRegister_MEM_out,
    output logic [63:0] WriteData_MEM_out,
    output logic        misaligned_err,
    output logic        timeout_err
);

    localparam int unsigned DATA_W = 64;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                we_q, we_d;
    logic [DATA_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   ld_buf_q, ld_buf_d;
    logic                rw_q, rw_d;
    logic [REG_W-1:0]    wreg_q, wreg_d;
    logic [DATA_W-1:0]   wd_q, wd_d;
    logic                mis_q, mis_d;
    logic                to_q, to_d;
    logic                stall_c;

    logic acc_c;
    logic aligned_c;

    assign acc_c     = write_enable_MEM_in | memtoreg_sel_MEM_in;
    assign aligned_c = (alu_result_MEM_in[2:0] == 3'b000);

    // Next-state, memory-port and MEM/WB update logic
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        ld_buf_d = ld_buf_q;
        rw_d     = rw_q;
        wreg_d   = wreg_q;
        wd_d     = wd_q;
        mis_d    = mis_q;
        to_d     = to_q;
        stall_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!acc_c) begin
                    rw_d   = RegWrite_MEM_in;
                    wreg_d = WriteRegister_MEM_in;
                    wd_d   = alu_result_MEM_in;
                end else if (aligned_c) begin
                    stall_c = 1'b1;
                    addr_d  = alu_result_MEM_in;
                    wdata_d = ReadData2_MEM_in;
                    we_d    = write_enable_MEM_in;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    rw_d    = 1'b0;
                    state_d = BUSY;
                end else begin
                    mis_d  = 1'b1;
                    rw_d   = 1'b0;
                    wreg_d = WriteRegister_MEM_in;
                    wd_d   = alu_result_MEM_in;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                rw_d    = 1'b0;
                // An ack in the last allowed cycle takes priority over the timeout
                if (mem_ack) begin
                    ld_buf_d = mem_rdata;
                    req_d    = 1'b0;
                    state_d  = DONE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    to_d     = 1'b1;
                    ld_buf_d = '0;
                    req_d    = 1'b0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                rw_d    = RegWrite_MEM_in;
                wreg_d  = WriteRegister_MEM_in;
                wd_d    = memtoreg_sel_MEM_in ? ld_buf_q : alu_result_MEM_in;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ld_buf_q <= '0;
            rw_q     <= 1'b0;
            wreg_q   <= '0;
            wd_q     <= '0;
            mis_q    <= 1'b0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            ld_buf_q <= ld_buf_d;
            rw_q     <= rw_d;
            wreg_q   <= wreg_d;
            wd_q     <= wd_d;
            mis_q    <= mis_d;
            to_q     <= to_d;
        end
    end

    assign mem_req               = req_q;
    assign mem_we                = we_q;
    assign mem_addr              = addr_q;
    assign mem_wdata             = wdata_q;
    assign stall_MEM             = stall_c;
    assign RegWrite_MEM_out      = rw_q;
    assign WriteRegister_MEM_out = wreg_q;
    assign WriteData_MEM_out     = wd_q;
    assign misaligned_err        = mis_q;
    assign timeout_err           = to_q;

endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access: an instruction-level timeline model predicts
// every output each cycle; directed cases pin the model with literal values.
module tb_mem_access;

    localparam int unsigned TIMEOUT = 16;

    logic        clk;
    logic        reset;
    logic        RegWrite_MEM_in;
    logic        write_enable_MEM_in;
    logic        memtoreg_sel_MEM_in;
    logic [4:0]  WriteRegister_MEM_in;
    logic [63:0] alu_result_MEM_in;
    logic [63:0] ReadData2_MEM_in;
    logic        mem_ack;
    logic [63:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic        stall_MEM;
    logic        RegWrite_MEM_out;
    logic [4:0]  WriteRegister_MEM_out;
    logic [63:0] WriteData_MEM_out;
    logic        misaligned_err;
    logic        timeout_err;

    mem_access #(.TIMEOUT(TIMEOUT)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .RegWrite_MEM_in       (RegWrite_MEM_in),
        .write_enable_MEM_in   (write_enable_MEM_in),
        .memtoreg_sel_MEM_in   (memtoreg_sel_MEM_in),
        .WriteRegister_MEM_in  (WriteRegister_MEM_in),
        .alu_result_MEM_in     (alu_result_MEM_in),
        .ReadData2_MEM_in      (ReadData2_MEM_in),
        .mem_ack               (mem_ack),
        .mem_rdata             (mem_rdata),
        .mem_req               (mem_req),
        .mem_we                (mem_we),
        .mem_addr              (mem_addr),
        .mem_wdata             (mem_wdata),
        .stall_MEM             (stall_MEM),
        .RegWrite_MEM_out      (RegWrite_MEM_out),
        .WriteRegister_MEM_out (WriteRegister_MEM_out),
        .WriteData_MEM_out     (WriteData_MEM_out),
        .misaligned_err        (misaligned_err),
        .timeout_err           (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected output values for the current cycle
    logic        m_rw, m_req, m_we, m_mis, m_to, exp_stall, chk_en;
    logic [4:0]  m_wreg;
    logic [63:0] m_wd, m_addr, m_wdata;
    int errors = 0;
    int checks = 0;
    int req_seen = 0;
    int stall_seen = 0;

    function automatic logic [63:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void compare_all();
        chk("stall_MEM", 64'(stall_MEM), 64'(exp_stall));
        chk("mem_req", 64'(mem_req), 64'(m_req));
        chk("mem_we", 64'(mem_we), 64'(m_we));
        chk("mem_addr", mem_addr, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("RegWrite_out", 64'(RegWrite_MEM_out), 64'(m_rw));
        chk("WriteRegister_out", 64'(WriteRegister_MEM_out), 64'(m_wreg));
        chk("WriteData_out", WriteData_MEM_out, m_wd);
        chk("misaligned_err", 64'(misaligned_err), 64'(m_mis));
        chk("timeout_err", 64'(timeout_err), 64'(m_to));
    endfunction

    // Check the current cycle at the falling edge, then advance past the next rising edge
    task automatic step();
        @(negedge clk);
        req_seen   += int'(mem_req);
        stall_seen += int'(stall_MEM);
        if (chk_en) compare_all();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rw, input logic we, input logic ld, input logic [4:0] wreg,
                         input logic [63:0] alu, input logic [63:0] rd2);
        RegWrite_MEM_in      = rw;
        write_enable_MEM_in  = we;
        memtoreg_sel_MEM_in  = ld;
        WriteRegister_MEM_in = wreg;
        alu_result_MEM_in    = alu;
        ReadData2_MEM_in     = rd2;
    endtask

    task automatic apply_reset();
        chk_en  = 1'b0;
        reset   = 1'b1;
        mem_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        step();
        m_rw = 0; m_req = 0; m_we = 0; m_mis = 0; m_to = 0;
        m_wreg = '0; m_wd = '0; m_addr = '0; m_wdata = '0;
        reset     = 1'b0;
        exp_stall = 1'b0;
        chk_en    = 1'b1;
    endtask

    // One instruction: lat = BUSY cycle carrying the ack (0 = never), rst_at = BUSY cycle to reset in
    task automatic do_instr(input logic rw, input logic we, input logic ld, input logic [4:0] wreg,
                            input logic [63:0] alu, input logic [63:0] rd2,
                            input int lat, input int rst_at, input logic [63:0] ack_data);
        logic [63:0] ld_data;
        bit acked;
        int n;
        drive(rw, we, ld, wreg, alu, rd2);
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = rand64();
        if (!(we | ld)) begin
            exp_stall = 1'b0;
            step();
            m_rw = rw; m_wreg = wreg; m_wd = alu;
            return;
        end
        if (alu[2:0] != 3'b000) begin
            exp_stall = 1'b0;
            step();
            m_rw = 1'b0; m_wreg = wreg; m_wd = alu; m_mis = 1'b1;
            return;
        end
        exp_stall = 1'b1;
        step();
        m_rw = 1'b0; m_req = 1'b1; m_we = we; m_addr = alu; m_wdata = rd2;
        n = (lat == 0 || lat > int'(TIMEOUT)) ? int'(TIMEOUT) : lat;
        acked   = 1'b0;
        ld_data = '0;
        for (int k = 1; k <= n; k++) begin
            mem_ack   = (k == lat);
            mem_rdata = (k == lat) ? ack_data : rand64();
            exp_stall = 1'b1;
            if (k == rst_at) begin
                apply_reset();
                return;
            end
            if (k == lat) begin
                acked   = 1'b1;
                ld_data = ack_data;
            end
            step();
        end
        m_req = 1'b0;
        if (!acked) m_to = 1'b1;
        mem_ack   = 1'($urandom_range(0, 1));
        mem_rdata = rand64();
        exp_stall = 1'b0;
        step();
        m_rw = rw; m_wreg = wreg; m_wd = ld ? ld_data : alu;
    endtask

    int s0, r0;
    int t, lat;

    initial begin
        reset = 1'b1;
        chk_en = 1'b0;
        exp_stall = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        apply_reset();

        // Reset state, then plain ALU op
        s0 = stall_seen;
        do_instr(1'b1, 1'b0, 1'b0, 5'd5, 64'h2A, rand64(), 0, 0, 64'd0);
        chk("t1_rw", 64'(RegWrite_MEM_out), 64'd1);
        chk("t1_wreg", 64'(WriteRegister_MEM_out), 64'd5);
        chk("t1_wd", WriteData_MEM_out, 64'h2A);
        chk("t1_no_stall", 64'(stall_seen - s0), 64'd0);

        // Zero-wait load
        s0 = stall_seen; r0 = req_seen;
        do_instr(1'b1, 1'b0, 1'b1, 5'd3, 64'h100, rand64(), 1, 0, 64'hDEADBEEF);
        chk("t2_stall_cycles", 64'(stall_seen - s0), 64'd2);
        chk("t2_req_cycles", 64'(req_seen - r0), 64'd1);
        chk("t2_addr", mem_addr, 64'h100);
        chk("t2_we", 64'(mem_we), 64'd0);
        chk("t2_wd", WriteData_MEM_out, 64'hDEADBEEF);
        chk("t2_rw", 64'(RegWrite_MEM_out), 64'd1);

        // Store with ack in fourth BUSY cycle
        r0 = req_seen;
        do_instr(1'b0, 1'b1, 1'b0, 5'd7, 64'h18, 64'h55, 4, 0, rand64());
        chk("t3_req_cycles", 64'(req_seen - r0), 64'd4);
        chk("t3_we", 64'(mem_we), 64'd1);
        chk("t3_wdata", mem_wdata, 64'h55);

        // Misaligned load
        s0 = stall_seen; r0 = req_seen;
        do_instr(1'b1, 1'b0, 1'b1, 5'd9, 64'h103, rand64(), 1, 0, rand64());
        chk("t4_mis", 64'(misaligned_err), 64'd1);
        chk("t4_rw", 64'(RegWrite_MEM_out), 64'd0);
        chk("t4_no_req", 64'(req_seen - r0), 64'd0);
        chk("t4_no_stall", 64'(stall_seen - s0), 64'd0);
        do_instr(1'b1, 1'b0, 1'b0, 5'd1, 64'h77, rand64(), 0, 0, 64'd0);
        chk("t4_mis_sticky", 64'(misaligned_err), 64'd1);

        // Timeout, then ack in the last allowed cycle
        r0 = req_seen;
        do_instr(1'b1, 1'b0, 1'b1, 5'd4, 64'h40, rand64(), 0, 0, 64'd0);
        chk("t5_req_cycles", 64'(req_seen - r0), 64'(TIMEOUT));
        chk("t5_to", 64'(timeout_err), 64'd1);
        chk("t5_wd", WriteData_MEM_out, 64'd0);
        apply_reset();
        do_instr(1'b1, 1'b0, 1'b1, 5'd4, 64'h48, rand64(), int'(TIMEOUT), 0, 64'h1234);
        chk("t5b_to", 64'(timeout_err), 64'd0);
        chk("t5b_wd", WriteData_MEM_out, 64'h1234);

        // Reset during BUSY, then a stray ack
        do_instr(1'b1, 1'b0, 1'b1, 5'd6, 64'h80, rand64(), 10, 3, rand64());
        chk("t6_req", 64'(mem_req), 64'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 64'd0, 64'd0);
        mem_ack   = 1'b1;
        mem_rdata = 64'hFFFF;
        exp_stall = 1'b0;
        step();
        mem_ack = 1'b0;
        chk("t6_req_after_ack", 64'(mem_req), 64'd0);
        chk("t6_wd", WriteData_MEM_out, 64'd0);
        chk("t6_rw", 64'(RegWrite_MEM_out), 64'd0);

        // Randomized instruction stream
        for (int i = 0; i < 300; i++) begin
            t   = int'($urandom_range(0, 19));
            lat = int'($urandom_range(0, 18));
            if (t < 8) begin
                do_instr(1'($urandom), 1'b0, 1'b0, 5'($urandom), rand64(), rand64(), 0, 0, 64'd0);
            end else if (t < 16) begin
                do_instr(1'($urandom), t[0], ~t[0], 5'($urandom), rand64() & ~64'h7,
                         rand64(), lat, 0, rand64());
            end else if (t < 18) begin
                do_instr(1'($urandom), t[0], ~t[0], 5'($urandom), rand64() | 64'h1,
                         rand64(), lat, 0, rand64());
            end else if (t == 18) begin
                do_instr(1'($urandom), 1'b0, 1'b1, 5'($urandom), rand64() & ~64'h7,
                         rand64(), 0, int'($urandom_range(1, 16)), rand64());
            end else begin
                apply_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
